hex_display_ctrl: RTL

Parametrised Avalon-MM seven-segment display controller for the Nios SoC. It replaces the bare 32-bit hex output register with per-digit hex decode, digit enable, decimal-point and blink control. Segment outputs drive the board HEX displays directly. The Nios core sees a zero-wait-state slave with four 32-bit registers.

---
 rtl/hex_display_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/hex_display_ctrl.sv
// Avalon-MM seven-segment controller: per-digit hex decode,
// digit enable, decimal point and blink, registered segment outputs.
module hex_display_ctrl #(
   parameter int NUM_DIGITS = 8,
   parameter bit ACTIVE_LOW = 1'b1,
   parameter int BLINK_DIV  = 25000000
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [1:0]              address,
   input  logic                    chipselect,
   input  logic                    write_n,
   input  logic [3:0]              byteenable,
   input  logic [31:0]             writedata,
   output logic [31:0]             readdata,
   output logic [8*NUM_DIGITS-1:0] seg
);

   localparam int CW = $clog2(BLINK_DIV);
   localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);
   localparam logic [63:0] DM64 = (64'd1 << (4*NUM_DIGITS)) - 64'd1;
   localparam logic [63:0] NM64 = (64'd1 << NUM_DIGITS) - 64'd1;
   localparam logic [31:0] DATA_MASK = DM64[31:0];
   localparam logic [31:0] DIG_MASK  = NM64[31:0];
   localparam logic [8*NUM_DIGITS-1:0] SEG_OFF = {(8*NUM_DIGITS){ACTIVE_LOW}};

   logic [31:0]             r_data;
   logic [31:0]             r_en;
   logic [31:0]             r_blink;
   logic [31:0]             r_dp;
   logic [CW-1:0]           r_cnt;
   logic                    r_phase;
   logic [8*NUM_DIGITS-1:0] r_seg;

   logic                    w_we;
   logic [31:0]             w_bmask;
   logic [8*NUM_DIGITS-1:0] w_seg_nxt;

   function automatic logic [6:0] dec(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

   function automatic logic [31:0] merge(
      input logic [31:0] old,
      input logic [31:0] wd,
      input logic [31:0] bm,
      input logic [31:0] keep
   );
      return ((old & ~bm) | (wd & bm)) & keep;
   endfunction

   assign w_we    = chipselect & ~write_n;
   assign w_bmask = {{8{byteenable[3]}}, {8{byteenable[2]}},
                     {8{byteenable[1]}}, {8{byteenable[0]}}};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_data  <= '0;
         r_en    <= DIG_MASK;
         r_blink <= '0;
         r_dp    <= '0;
      end else if (w_we) begin
         case (address)
            2'd0: r_data  <= merge(r_data, writedata, w_bmask, DATA_MASK);
            2'd1: r_en    <= merge(r_en, writedata, w_bmask, DIG_MASK);
            2'd2: r_blink <= merge(r_blink, writedata, w_bmask, DIG_MASK);
            default: r_dp <= merge(r_dp, writedata, w_bmask, DIG_MASK);
         endcase
      end
   end

   // Free-running blink timebase; register writes never disturb it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt   <= '0;
         r_phase <= 1'b0;
      end else if (r_cnt == CNT_MAX) begin
         r_cnt   <= '0;
         r_phase <= ~r_phase;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   always_comb begin
      w_seg_nxt = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (r_en[i] && !(r_blink[i] && r_phase))
            w_seg_nxt[8*i +: 8] = {r_dp[i], dec(r_data[4*i +: 4])};
      end
      w_seg_nxt = w_seg_nxt ^ SEG_OFF;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_seg <= SEG_OFF;
      else          r_seg <= w_seg_nxt;
   end

   assign seg = r_seg;

   always_comb begin
      readdata = '0;
      case (address)
         2'd0: readdata = r_data;
         2'd1: readdata = r_en;
         2'd2: readdata = r_blink | {r_phase, 31'd0};
         default: readdata = r_dp;
      endcase
   end

endmodule
